// File: rtl/led_zone_scheduler.sv
// led_zone_scheduler
//   Owns the ZONES x DW brightness table that feeds the MiniLED driver. A fill
//   comes either from the video zone stream or from a built-in test pattern, as
//   chosen by I_led_mode. Every fill lands in a shadow buffer. The shadow is
//   copied to the active table only on a driver frame sync, so the panel never
//   shows a torn frame.
//
//   Optional build macro: ZONE_SCHED_GAMMA_EN. When it is defined, every shadow
//   write stores (v*v)>>DW. When it is not defined, the raw value is stored.
//
// Ports
//   I_clk, I_rst_n       clock, asynchronous active-low reset
//   I_led_mode           00 video, 01 full-on, 10 gradient, 11 breathing
//   I_vid_valid/zone/data/last, O_vid_ready   video zone beat handshake
//   I_frame_sync         1-cycle end-of-scan pulse from the driver
//   O_led_light          registered active table, zone k at [k*DW +: DW]
//   O_swap               high on the cycle the new active table is visible
//   O_zone_err           sticky flag: a video beat addressed a zone >= ZONES
module led_zone_scheduler #(
  parameter int unsigned ZONES    = 360,
  parameter int unsigned DW       = 8,
  parameter int unsigned ZW       = 9,
  parameter int unsigned RAMP_DIV = 5_000_000
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic [1:0]          I_led_mode,
  input  logic                I_vid_valid,
  input  logic [ZW-1:0]       I_vid_zone,
  input  logic [DW-1:0]       I_vid_data,
  input  logic                I_vid_last,
  output logic                O_vid_ready,
  input  logic                I_frame_sync,
  output logic [ZONES*DW-1:0] O_led_light,
  output logic                O_swap,
  output logic                O_zone_err
);

  localparam int unsigned DivW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(RAMP_DIV - 1);
  localparam logic [ZW-1:0] LastZone = ZW'(ZONES - 1);

  typedef enum logic [2:0] {StIdle, StFillVid, StFillTest, StPending, StSwap} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ZW-1:0]       zcnt_q, zcnt_d;
  logic [7:0]          ramp_q, ramp_lat_q, ramp_lat_d;
  logic [DivW-1:0]     div_q;
  logic                zone_err_q, zone_err_d;
  logic [ZONES*DW-1:0] shadow_q, active_q;

  logic                wr_en;
  logic [ZW-1:0]       wr_zone;
  logic [DW-1:0]       wr_raw;
  logic [7:0]          pat;
  logic                load_active;
  int unsigned         wr_base;

  // Gamma shaping sits on the write path, so write timing is the same either way.
  function automatic logic [DW-1:0] shape(input logic [DW-1:0] v);
`ifdef ZONE_SCHED_GAMMA_EN
    logic [2*DW-1:0] prod;
    prod = v * v;
    return prod[2*DW-1:DW];
`else
    return v;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    zcnt_d      = zcnt_q;
    ramp_lat_d  = ramp_lat_q;
    zone_err_d  = zone_err_q;
    wr_en       = 1'b0;
    wr_zone     = '0;
    wr_raw      = '0;
    pat         = '0;
    load_active = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Mode and ramp are captured here and then held for the whole fill.
        mode_d     = I_led_mode;
        ramp_lat_d = ramp_q;
        zcnt_d     = '0;
        state_d    = (I_led_mode == 2'b00) ? StFillVid : StFillTest;
      end
      StFillVid: begin
        if (I_vid_valid) begin
          if (I_vid_zone <= LastZone) begin
            wr_en   = 1'b1;
            wr_zone = I_vid_zone;
            wr_raw  = I_vid_data;
          end else begin
            zone_err_d = 1'b1;
          end
          if (I_vid_last) state_d = StPending;
        end
      end
      StFillTest: begin
        case (mode_q)
          2'b01:   pat = 8'hFF;
          2'b10:   pat = zcnt_q[7:0];
          default: pat = ramp_lat_q;
        endcase
        wr_en   = 1'b1;
        wr_zone = zcnt_q;
        wr_raw  = DW'(pat);
        if (zcnt_q == LastZone) state_d = StPending;
        else                    zcnt_d  = zcnt_q + ZW'(1);
      end
      StPending: begin
        if (I_frame_sync) begin
          load_active = 1'b1;
          state_d     = StSwap;
        end
      end
      StSwap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    wr_base = 32'(wr_zone) * DW;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 2'b00;
      zcnt_q     <= '0;
      ramp_q     <= '0;
      ramp_lat_q <= '0;
      div_q      <= '0;
      zone_err_q <= 1'b0;
      shadow_q   <= '0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      zcnt_q     <= zcnt_d;
      ramp_lat_q <= ramp_lat_d;
      zone_err_q <= zone_err_d;
      // The ramp divider runs in every state.
      if (div_q == DivLast) begin
        div_q  <= '0;
        ramp_q <= ramp_q + 8'd1;
      end else begin
        div_q <= div_q + DivW'(1);
      end
      if (wr_en) shadow_q[wr_base +: DW] <= shape(wr_raw);
      // The load happens on the edge into StSwap, so the data is visible while O_swap is high.
      if (load_active) active_q <= shadow_q;
    end
  end

  assign O_vid_ready = (state_q == StFillVid);
  assign O_swap      = (state_q == StSwap);
  assign O_zone_err  = zone_err_q;
  assign O_led_light = active_q;

endmodule
